// File: rtl/booth_mac_sched.sv
// Round-robin front end that shares one sequential Booth multiplier between NREQ requesters and keeps a signed accumulator per requester.
// Optional: define BOOTH_MAC_SCHED_SAT_EN to make the accumulate step saturate instead of wrap.
module booth_mac_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 16,
    parameter int ACC_W = 40,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ*W-1:0]   req_a_i,
    input  logic [NREQ*W-1:0]   req_b_i,
    input  logic [NREQ-1:0]     req_clr_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic                mul_start_o,
    output logic [W-1:0]        mul_a_o,
    output logic [W-1:0]        mul_b_o,
    input  logic                mul_done_i,
    input  logic [2*W-1:0]      mul_p_i,
    output logic                resp_valid_o,
    output logic [IDW-1:0]      resp_id_o,
    output logic [ACC_W-1:0]    resp_acc_o,
    input  logic                resp_ready_i,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     gid_q;
    logic [W-1:0]       a_q, b_q;
    logic               clr_q;
    logic [2*W-1:0]     p_q;
    logic [ACC_W-1:0]   acc_q [NREQ];

    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     scan_idx;
    int                 scan_k;
    logic [W-1:0]       grant_a, grant_b;
    logic               grant_clr;
    logic [IDW-1:0]     ptr_next;
    logic [ACC_W-1:0]   acc_sel, p_ext, acc_sum, acc_new;

    // Rotating priority search: the first valid requester at or above ptr wins, wrapping past NREQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        scan_k      = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_k = int'(ptr_q) + i;
            if (scan_k >= NREQ) begin
                scan_k = scan_k - NREQ;
            end
            scan_idx = IDW'(scan_k);
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_comb begin
        grant_a   = '0;
        grant_b   = '0;
        grant_clr = 1'b0;
        acc_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id) begin
                grant_a   = req_a_i[i*W +: W];
                grant_b   = req_b_i[i*W +: W];
                grant_clr = req_clr_i[i];
            end
            if (IDW'(i) == gid_q) begin
                acc_sel = acc_q[i];
            end
        end
    end

    assign p_ext   = ACC_W'($signed(p_q));
    assign acc_sum = acc_sel + p_ext;

    // Overflow only when both addends share a sign and the sum's sign flips; the clr load is a plain sign extension.
`ifdef BOOTH_MAC_SCHED_SAT_EN
    always_comb begin
        if (clr_q) begin
            acc_new = p_ext;
        end else if ((acc_sel[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_sel[ACC_W-1])) begin
            acc_new = acc_sel[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_new = acc_sum;
        end
    end
`else
    assign acc_new = clr_q ? p_ext : acc_sum;
`endif

    assign ptr_next = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is gated by rst_n so every output reads zero while reset is held.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = '0;
        mul_start_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_id_o    = '0;
        resp_acc_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found && rst_n) begin
                    req_ready_o = NREQ'(1) << grant_id;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done_i) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_id_o    = gid_q;
                resp_acc_o   = acc_sel;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            gid_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            clr_q <= 1'b0;
            p_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (state_q == S_IDLE && grant_found) begin
                gid_q <= grant_id;
                a_q   <= grant_a;
                b_q   <= grant_b;
                clr_q <= grant_clr;
            end
            if (state_q == S_WAIT && mul_done_i) begin
                p_q <= mul_p_i;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (state_q == S_ACC && gid_q == IDW'(i)) begin
                    acc_q[i] <= acc_new;
                end
            end
            if (state_q == S_RESP && resp_ready_i) begin
                ptr_q <= ptr_next;
            end
        end
    end

    assign mul_a_o = a_q;
    assign mul_b_o = b_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_mac_sched.sv
// Directed bench for booth_mac_sched: scoreboard of expected (id, accumulator) pairs plus a behavioural multiplier.
// Expected overflow result follows BOOTH_MAC_SCHED_SAT_EN when it is defined for the build.
module tb_booth_mac_sched;

    typedef struct packed {
        logic [1:0]  id;
        logic [39:0] acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_clr;
    logic [3:0]  req_ready;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_p;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [39:0] resp_acc;
    logic        resp_ready;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          grantCycle = 0;
    logic [39:0] lastAcc;
    logic [39:0] mAcc [4];
    exp_t        sbQ [$];
    logic [15:0] fairA [4] = '{16'd7, 16'hFFFD, 16'd100, 16'hFF06};
    logic [15:0] fairB [4] = '{16'd9, 16'd11, 16'hFFF4, 16'hFFD8};

    booth_mac_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_clr_i    (req_clr),
        .req_ready_o  (req_ready),
        .mul_start_o  (mul_start),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_done_i   (mul_done),
        .mul_p_i      (mul_p),
        .resp_valid_o (resp_valid),
        .resp_id_o    (resp_id),
        .resp_acc_o   (resp_acc),
        .resp_ready_i (resp_ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [39:0] nextAcc(input logic [39:0] cur, input logic [15:0] a,
                                           input logic [15:0] b, input logic clr);
        logic signed [31:0] p;
        logic [39:0]        ext;
        logic [39:0]        sum;
        p   = $signed(a) * $signed(b);
        ext = {{8{p[31]}}, p};
        sum = cur + ext;
`ifdef BOOTH_MAC_SCHED_SAT_EN
        if (cur[39] == ext[39] && sum[39] != cur[39]) begin
            sum = cur[39] ? 40'h80_0000_0000 : 40'h7F_FFFF_FFFF;
        end
`endif
        return clr ? ext : sum;
    endfunction

    task automatic pushExpected(input int id, input logic [15:0] a, input logic [15:0] b, input logic clr);
        exp_t e;
        mAcc[id] = nextAcc(mAcc[id], a, b, clr);
        e.id     = 2'(id);
        e.acc    = mAcc[id];
        sbQ.push_back(e);
    endtask

    task automatic waitGrant(input int id);
        int         n;
        logic [3:0] oneHot;
        n = 0;
        #1;
        while (req_ready === 4'b0000 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        oneHot = 4'(1) << id;
        checkOutput("grant", 64'(req_ready), 64'(oneHot));
        grantCycle = cycleCnt;
    endtask

    task automatic issueCheck(input logic [15:0] a, input logic [15:0] b);
        checkOutput("mul_start", 64'(mul_start), 64'(1));
        checkOutput("mul_a", 64'(mul_a), 64'(a));
        checkOutput("mul_b", 64'(mul_b), 64'(b));
        checkOutput("ready_after_grant", 64'(req_ready), 64'(0));
    endtask

    // Called on the negedge of the ISSUE cycle; plays the multiplier, optionally asserting done again during ACC.
    task automatic serveRest(input int delay, input bit spurAcc);
        @(negedge clk);
        repeat (delay) begin
            checkOutput("stall_busy", 64'(busy), 64'(1));
            checkOutput("stall_start", 64'(mul_start), 64'(0));
            @(negedge clk);
        end
        mul_done = 1'b1;
        mul_p    = $signed(mul_a) * $signed(mul_b);
        @(negedge clk);
        if (spurAcc) begin
            mul_p = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        mul_done = 1'b0;
    endtask

    task automatic collectResp(input int hold, input int expLat);
        int   n;
        exp_t e;
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_valid", 64'(resp_valid), 64'(1));
        checkOutput("latency", 64'(cycleCnt - grantCycle), 64'(expLat));
        checkOutput("sb_nonempty", 64'(sbQ.size() > 0), 64'(1));
        e = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        checkOutput("resp_id", 64'(resp_id), 64'(e.id));
        checkOutput("resp_acc", 64'(resp_acc), 64'(e.acc));
        lastAcc = resp_acc;
        repeat (hold) begin
            @(negedge clk);
            checkOutput("bp_valid", 64'(resp_valid), 64'(1));
            checkOutput("bp_id", 64'(resp_id), 64'(e.id));
            checkOutput("bp_acc", 64'(resp_acc), 64'(e.acc));
            checkOutput("bp_ready", 64'(req_ready), 64'(0));
            checkOutput("bp_start", 64'(mul_start), 64'(0));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("resp_drop", 64'(resp_valid), 64'(0));
    endtask

    task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b, input logic clr,
                                 input int delay, input int hold, input bit spurAcc);
        req_valid[id]          = 1'b1;
        req_a[id*16 +: 16]     = a;
        req_b[id*16 +: 16]     = b;
        req_clr[id]            = clr;
        waitGrant(id);
        pushExpected(id, a, b, clr);
        @(negedge clk);
        req_valid[id] = 1'b0;
        issueCheck(a, b);
        serveRest(delay, spurAcc);
        collectResp(hold, 4 + delay);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        checkOutput({tag, "_mul_start"}, 64'(mul_start), 64'(0));
        checkOutput({tag, "_mul_a"}, 64'(mul_a), 64'(0));
        checkOutput({tag, "_mul_b"}, 64'(mul_b), 64'(0));
        checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        checkOutput({tag, "_resp_id"}, 64'(resp_id), 64'(0));
        checkOutput({tag, "_resp_acc"}, 64'(resp_acc), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        req_a      = '0;
        req_b      = '0;
        req_clr    = '0;
        mul_done   = 1'b0;
        mul_p      = '0;
        resp_ready = 1'b0;
        lastAcc    = '0;
        for (int i = 0; i < 4; i++) mAcc[i] = '0;

        // Reset values, with requests pending to show req_ready is held low.
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Fairness: all requesters valid continuously, grants rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = fairA[i];
            req_b[i*16 +: 16] = fairB[i];
        end
        req_clr   = 4'h0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            waitGrant(k % 4);
            pushExpected(k % 4, fairA[k % 4], fairB[k % 4], 1'b0);
            @(negedge clk);
            if (k == 4) req_valid = 4'h0;
            issueCheck(fairA[k % 4], fairB[k % 4]);
            serveRest(0, 1'b0);
            collectResp(0, 4);
        end

        // Single requester: load then accumulate.
        applyStimulus(0, 16'd3, 16'hFFFB, 1'b1, 0, 0, 1'b0);
        checkOutput("single_load", 64'(lastAcc), 64'(40'hFF_FFFF_FFF1));
        applyStimulus(0, 16'd2, 16'd4, 1'b0, 0, 0, 1'b0);
        checkOutput("single_acc", 64'(lastAcc), 64'(40'hFF_FFFF_FFF9));

        // Response backpressure for 10 cycles.
        applyStimulus(2, 16'hFFF9, 16'd6, 1'b0, 0, 10, 1'b0);

        // Spurious done in IDLE, then in ACC.
        mul_done = 1'b1;
        mul_p    = 32'h1234_5678;
        repeat (2) @(negedge clk);
        mul_done = 1'b0;
        checkOutput("spur_idle_busy", 64'(busy), 64'(0));
        checkOutput("spur_idle_resp", 64'(resp_valid), 64'(0));
        applyStimulus(0, 16'd5, 16'd5, 1'b0, 0, 0, 1'b1);
        checkOutput("spur_acc_value", 64'(lastAcc), 64'(40'd18));
        applyStimulus(0, 16'd1, 16'd1, 1'b0, 0, 0, 1'b0);

        // Stretched done: 40 cycles in WAIT.
        applyStimulus(3, 16'hFF9C, 16'hFF9C, 1'b0, 40, 0, 1'b0);

        // Overflow on requester 1: build 2^39-1 from in-range products, then add 1.
        applyStimulus(1, 16'h8000, 16'h8000, 1'b1, 0, 0, 1'b0);
        for (int k = 0; k < 510; k++) begin
            applyStimulus(1, 16'h8000, 16'h8000, 1'b0, 0, 0, 1'b0);
        end
        applyStimulus(1, 16'h7FFF, 16'h7FFF, 1'b0, 0, 0, 1'b0);
        applyStimulus(1, 16'd2, 16'h7FFF, 1'b0, 0, 0, 1'b0);
        checkOutput("ovf_preload", 64'(lastAcc), 64'(40'h7F_FFFF_FFFF));
        applyStimulus(1, 16'd1, 16'd1, 1'b0, 0, 0, 1'b0);
`ifdef BOOTH_MAC_SCHED_SAT_EN
        checkOutput("ovf_result", 64'(lastAcc), 64'(40'h7F_FFFF_FFFF));
`else
        checkOutput("ovf_result", 64'(lastAcc), 64'(40'h80_0000_0000));
`endif

        // Reset during WAIT, late done afterwards, then fresh requests.
        req_valid[2]     = 1'b1;
        req_a[32 +: 16]  = 16'd9;
        req_b[32 +: 16]  = 16'd9;
        req_clr[2]       = 1'b0;
        waitGrant(2);
        @(negedge clk);
        req_valid[2] = 1'b0;
        issueCheck(16'd9, 16'd9);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_busy", 64'(busy), 64'(1));
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'h0;
        for (int i = 0; i < 4; i++) mAcc[i] = '0;
        @(negedge clk);
        mul_done = 1'b1;
        mul_p    = 32'd81;
        @(negedge clk);
        mul_done = 1'b0;
        checkOutput("late_done_busy", 64'(busy), 64'(0));
        checkOutput("late_done_resp", 64'(resp_valid), 64'(0));

        req_a[0 +: 16]  = 16'd1;
        req_b[0 +: 16]  = 16'd1;
        req_a[48 +: 16] = 16'd2;
        req_b[48 +: 16] = 16'd3;
        req_clr         = 4'h0;
        req_valid       = 4'b1001;
        waitGrant(0);
        pushExpected(0, 16'd1, 16'd1, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        issueCheck(16'd1, 16'd1);
        serveRest(0, 1'b0);
        collectResp(0, 4);
        checkOutput("post_reset_acc", 64'(lastAcc), 64'(40'd1));
        waitGrant(3);
        pushExpected(3, 16'd2, 16'd3, 1'b0);
        @(negedge clk);
        req_valid[3] = 1'b0;
        issueCheck(16'd2, 16'd3);
        serveRest(0, 1'b0);
        collectResp(0, 4);
        checkOutput("post_reset_acc3", 64'(lastAcc), 64'(40'd6));

        checkOutput("sb_drained", 64'(sbQ.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
